// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   mdu_state_e : controller states (IDLE, RUN, FIX, DONE)
//   OP_MUL/OP_DIV : encoding of the op input
//   MDU_W : operand width, MDU_ITER : iterations per operation
package mdu_pkg;

    localparam int unsigned MDU_W    = 32;
    localparam int unsigned MDU_ITER = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_abs.sv
// mdu_abs: combinational conditional two's-complement negate.
// Tie neg to the operand's sign bit to get its magnitude, or to a computed
// sign to restore a signed value from a magnitude.
//   value : 32-bit input
//   neg   : 1 = output -value, 0 = output value
//   y     : result (the magnitude of -2^31 comes out as 32'h80000000 unsigned)
module mdu_abs
    import mdu_pkg::*;
(
    input  logic [MDU_W-1:0] value,
    input  logic             neg,
    output logic [MDU_W-1:0] y
);

    assign y = neg ? (~value + MDU_W'(1)) : value;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit signed multiply (radix-2 Booth) and divide
// (restoring, on magnitudes) with a four-state controller.
//   clk         : clock, rising edge
//   clr         : asynchronous active-low reset
//   start       : request, sampled only in IDLE
//   op          : 0 = signed multiply, 1 = signed divide
//   a, b        : operands (two's complement)
//   busy        : high in RUN and FIX
//   done        : one-cycle pulse in DONE, result valid
//   div_by_zero : high with done when a divide had b == 0
//   result      : multiply: product; divide: {remainder, quotient}
// Build option: define MDU_DIV_EN to include the divide datapath. Without it,
// a divide request completes immediately with result 0.
module mul_div_unit
    import mdu_pkg::*;
(
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               op,
    input  logic [MDU_W-1:0]   a,
    input  logic [MDU_W-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*MDU_W-1:0] result
);

    mdu_state_e state_q, state_d;

    logic [5:0]           cnt_q;
    logic [MDU_W-1:0]     m_q;       // multiplicand, or divisor magnitude
    // Multiply layout: {33-bit upper accumulator, 32-bit multiplier, Booth q(-1)}.
    // The extra upper bit keeps -(-2^31) representable.
    // Divide layout:   {2'b00, remainder, quotient/dividend}.
    logic [2*MDU_W+1:0]   acc_q;
    logic [2*MDU_W+1:0]   step;
    logic [2*MDU_W-1:0]   result_q;
    logic [2*MDU_W-1:0]   fixed;
    logic                 short_cut; // request completes without iterating

    // Booth step
    logic [MDU_W:0]       mul_hi, mul_sum;
    logic [2*MDU_W+1:0]   mul_next;

    always_comb begin
        mul_hi = acc_q[2*MDU_W+1:MDU_W+1];
        case ({acc_q[1], acc_q[0]})
            2'b01:   mul_sum = mul_hi + {m_q[MDU_W-1], m_q};
            2'b10:   mul_sum = mul_hi - {m_q[MDU_W-1], m_q};
            default: mul_sum = mul_hi;
        endcase
        mul_next = {mul_sum[MDU_W], mul_sum, acc_q[MDU_W:1]};
    end

`ifdef MDU_DIV_EN
    logic                 op_q;
    logic                 sa_q, sb_q;
    logic                 dbz_q;
    logic                 div_zero;
    logic [MDU_W-1:0]     a_mag, b_mag, quo_fix, rem_fix;
    logic [MDU_W:0]       div_shift, div_trial;
    logic                 div_ge;
    logic [2*MDU_W+1:0]   div_next;

    mdu_abs u_abs_a (.value(a), .neg(a[MDU_W-1]), .y(a_mag));
    mdu_abs u_abs_b (.value(b), .neg(b[MDU_W-1]), .y(b_mag));

    // Quotient sign is the XOR of operand signs; remainder follows the dividend.
    mdu_abs u_fix_q (.value(acc_q[MDU_W-1:0]),       .neg(sa_q ^ sb_q), .y(quo_fix));
    mdu_abs u_fix_r (.value(acc_q[2*MDU_W-1:MDU_W]), .neg(sa_q),        .y(rem_fix));

    assign div_zero  = (op == OP_DIV) && (b == '0);
    assign short_cut = div_zero;

    // Restoring step: partial remainder < divisor <= 2^31, so the shifted value
    // fits in 32 bits and bit 32 of the trial difference is a clean borrow.
    always_comb begin
        div_shift = {acc_q[2*MDU_W-1:MDU_W], acc_q[MDU_W-1]};
        div_trial = div_shift - {1'b0, m_q};
        div_ge    = ~div_trial[MDU_W];
        div_next  = {2'b00,
                     div_ge ? div_trial[MDU_W-1:0] : div_shift[MDU_W-1:0],
                     acc_q[MDU_W-2:0], div_ge};
    end

    assign step        = (op_q == OP_DIV) ? div_next : mul_next;
    assign fixed       = (op_q == OP_DIV) ? {rem_fix, quo_fix} : acc_q[2*MDU_W:1];
    assign div_by_zero = (state_q == DONE) && dbz_q;
`else
    assign short_cut   = (op == OP_DIV);
    assign step        = mul_next;
    assign fixed       = acc_q[2*MDU_W:1];
    assign div_by_zero = 1'b0;
`endif

    // Controller
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = short_cut ? DONE : RUN;
            RUN:  if (cnt_q == 6'(MDU_ITER - 1)) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q    <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
`ifdef MDU_DIV_EN
            op_q     <= OP_MUL;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dbz_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q <= '0;
`ifdef MDU_DIV_EN
                        op_q  <= op;
                        sa_q  <= a[MDU_W-1];
                        sb_q  <= b[MDU_W-1];
                        dbz_q <= div_zero;
                        if (op == OP_DIV) begin
                            m_q   <= b_mag;
                            acc_q <= {{(MDU_W+2){1'b0}}, a_mag};
                        end else begin
                            m_q   <= a;
                            acc_q <= {{(MDU_W+1){1'b0}}, b, 1'b0};
                        end
                        if (div_zero) result_q <= {a, {MDU_W{1'b1}}};
`else
                        m_q   <= a;
                        acc_q <= {{(MDU_W+1){1'b0}}, b, 1'b0};
                        if (op == OP_DIV) result_q <= '0;
`endif
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 6'd1;
                    acc_q <= step;
                end
                FIX: result_q <= fixed;
                default: ;
            endcase
        end
    end

    assign busy   = (state_q == RUN) || (state_q == FIX);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have the following ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  asynchronous, active-low reset.
- start  input  1  operation request; sampled only in IDLE.
- op  input  1  0 = signed multiply, 1 = signed divide.
- a  input  32  multiplicand / dividend (two's complement).
- b  input  32  multiplier / divisor (two's complement).
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse; result valid; drives Z-register load enable.
- div_by_zero  output  1  high with done when a divide had b == 0.
- result  output  64  multiply: full product; divide: [63:32] remainder, [31:0] quotient.
REQ-002 SHALL have no parameters; width is fixed at 32/64.

Function
REQ-003 SHALL use states IDLE, RUN, FIX, DONE.
REQ-004 IDLE with start=1 at edge k SHALL latch a, b and op, clear the iteration count, and enter RUN.
REQ-005 RUN SHALL perform one iteration per edge for exactly 32 edges (k+1..k+32), then enter FIX.
REQ-006 Multiply SHALL use radix-2 Booth recoding on the 64-bit accumulator.
REQ-007 Divide SHALL use restoring division on operand magnitudes.
REQ-008 FIX at edge k+33 SHALL apply the sign correction, register result, and enter DONE.
REQ-009 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-010 busy SHALL be 1 in RUN and FIX, and 0 in IDLE and DONE.
REQ-011 Quotient SHALL truncate toward zero; remainder sign SHALL equal dividend sign.
REQ-012 -2^31 / -1 SHALL yield quotient 32'h80000000 and remainder 0, with no error flag.
REQ-013 Divide with b == 0:
- IDLE goes to DONE directly at edge k.
- result = {a, 32'hFFFFFFFF}.
- div_by_zero = 1 during the done cycle.
REQ-014 div_by_zero SHALL be 0 in every cycle other than a divide-by-zero done cycle.
REQ-015 start SHALL be ignored in RUN, FIX and DONE; the earliest new acceptance is the cycle after DONE.
REQ-016 result SHALL change only at the FIX edge or the divide-by-zero edge, and SHALL otherwise hold across idle cycles.
REQ-017 Changes on a, b and op after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-018 clr = 0 SHALL immediately, regardless of clk:
- force IDLE;
- busy = 0, done = 0, div_by_zero = 0;
- result = 64'h0;
- iteration count = 0.
REQ-019 Reset mid-operation SHALL abandon it with no done pulse.
REQ-020 The first start SHALL be accepted on the first edge after clr deasserts.

Configuration
REQ-021 Macro MDU_DIV_EN defined: divide path present as specified above.
REQ-022 MDU_DIV_EN undefined:
- divide datapath absent;
- op = 1 start goes IDLE to DONE at edge k;
- result = 64'h0 and div_by_zero = 0;
- multiply behaviour unchanged.

Structure
REQ-023 Shared package mdu_pkg SHALL hold:
- state enum;
- op encoding constants (OP_MUL, OP_DIV);
- MDU_ITER = 32;
- MDU_W = 32.
REQ-024 One sub-module, mdu_abs, SHALL provide combinational 32-bit magnitude and conditional negate; it is instantiated for operand and result sign handling.
REQ-025 FSM and datapath SHALL remain in mul_div_unit; no further hierarchy.

Verification
REQ-026 The bench SHALL cover:
- Multiply: a=7, b=-3 (32'hFFFFFFFD), start at edge k -> done pulse in the cycle after edge k+33, result 64'hFFFFFFFF_FFFFFFEB, busy high k+1..k+33.
- Multiply: a=b=32'h80000000 -> result 64'h40000000_00000000.
- Divide: a=-7, b=2 -> result {32'hFFFFFFFF, 32'hFFFFFFFD}, div_by_zero=0.
- Divide: a=5, b=0 -> done in the cycle after edge k, result {32'h00000005, 32'hFFFFFFFF}, div_by_zero=1.
- Divide: a=32'h80000000, b=32'hFFFFFFFF -> result {32'h0, 32'h80000000}.
- Disturbance: start pulsed at RUN iteration 5 -> ignored; clr low at iteration 10 -> busy=0 and result=0 immediately, no done; next start completes normally.
